// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: instruction sequencer for a Bennett-clocked ALU.
// Accepts 16-bit instructions over a valid/ready handshake and holds a
// one-deep pending slot. Each instruction is decoded into ALU control bits
// on a Bennett cycle boundary (rising edge of instFlag). The operand and
// result latch strobes are issued when the phase rails peak.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   instFlag              Bennett cycle boundary flag
//   clkpos, clkneg        Bennett phase rails (WIDTH bits), used for peak detection
//   in_valid, in_ready    instruction handshake
//   in_instr              instruction word, opcode in [15:12]
//   instr_in              held instruction word for the ALU immediate path
//   ALU_Control*, A_mux, B_mux*, SUB, STL, Adder_Cin, mux3_*   ALU control bits
//   A_Fclkpos, ALU_O_Fclkpos   one-clk operand / result latch strobes
//   done                  pulse when an executed instruction's Bennett cycle closes
//   illegal, overrun      sticky error flags
//   op_count              count of done pulses (only with ALU_CTRL_SEQ_PERF_EN)
//
// Build option: define ALU_CTRL_SEQ_PERF_EN to add the op_count output.

module alu_ctrl_seq #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instFlag,
    input  logic [WIDTH-1:0] clkpos,
    input  logic [WIDTH-1:0] clkneg,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    output logic [15:0]      instr_in,
    output logic             ALU_Control0,
    output logic             ALU_Control1,
    output logic             A_mux,
    output logic             B_mux0,
    output logic             B_mux1,
    output logic             SUB,
    output logic             STL,
    output logic             Adder_Cin,
    output logic             mux3_0,
    output logic             mux3_1,
    output logic             A_Fclkpos,
    output logic             ALU_O_Fclkpos,
    output logic             done,
    output logic             illegal,
    output logic             overrun
`ifdef ALU_CTRL_SEQ_PERF_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam int unsigned CTRL_W = 10;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_EXEC = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Control vector order:
    // {ALU_Control1, ALU_Control0, A_mux, B_mux1, B_mux0, SUB, STL, Adder_Cin, mux3_1, mux3_0}
    function automatic logic [CTRL_W-1:0] decode(input logic [3:0] op);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (op)
            4'd1:    c = 10'b10_1_11_0_0_0_00;  // ADD
            4'd2:    c = 10'b10_1_11_1_0_1_00;  // SUB
            4'd3:    c = 10'b00_1_11_0_0_0_00;  // AND
            4'd4:    c = 10'b01_1_11_0_0_0_00;  // OR
            4'd5:    c = 10'b11_1_11_1_1_1_00;  // SLT
            4'd6:    c = 10'b10_1_01_0_0_0_00;  // ADDI
            4'd7:    c = 10'b10_0_10_0_0_0_01;  // PCADD
            default: c = '0;                    // NOP and illegal opcodes
        endcase
        return c;
    endfunction

    state_t              r_state;
    logic                r_flag_d;
    logic                r_pend_v;
    logic [INSTR_W-1:0]  r_pend;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_a_stb;
    logic                r_alu_o_stb;
    logic                r_done;
    logic                r_illegal;
    logic                r_overrun;
    logic                r_in_ready;

    logic                w_flag_rise;
    logic                w_peak;
    logic                w_xfer;
    logic                w_close;
    logic [INSTR_W-1:0]  w_load_word;
    logic [CTRL_W-1:0]   w_load_ctrl;

    // Edge/peak detection and load-source selection
    always_comb begin
        w_flag_rise = instFlag & ~r_flag_d;
        w_peak      = (&clkpos) & ~(|clkneg);
        w_xfer      = in_valid & r_in_ready;
        w_close     = w_flag_rise & ((r_state == S_EXEC) | (r_state == S_HOLD));
        // A HOLD-state load with an empty slot can only come from a same-cycle transfer
        w_load_word = ((r_state == S_HOLD) && !r_pend_v) ? in_instr : r_pend;
        w_load_ctrl = decode(w_load_word[15:12]);
    end

    // Sequencer state, pending slot and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_flag_d    <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend      <= '0;
            r_ctrl      <= '0;
            r_instr     <= '0;
            r_a_stb     <= 1'b0;
            r_alu_o_stb <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_overrun   <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_flag_d    <= instFlag;
            r_done      <= w_close;
            r_a_stb     <= 1'b0;
            r_alu_o_stb <= r_a_stb;  // result strobe trails the operand strobe by one clk

            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_pend     <= in_instr;
                        r_pend_v   <= 1'b1;
                        r_state    <= S_ARM;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end

                S_ARM: begin
                    r_in_ready <= 1'b0;
                    if (w_flag_rise) begin
                        r_ctrl    <= w_load_ctrl;
                        r_instr   <= w_load_word;
                        r_illegal <= r_illegal | w_load_word[15];
                        r_pend_v  <= 1'b0;
                        r_state   <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (w_flag_rise) begin
                        // Cycle closed without a strobe; the slot is empty here
                        r_overrun  <= 1'b1;
                        r_ctrl     <= '0;
                        r_instr    <= '0;
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                    end else if (w_peak) begin
                        r_a_stb    <= 1'b1;
                        r_state    <= S_HOLD;
                        r_in_ready <= ~r_pend_v;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (w_flag_rise) begin
                        if (r_pend_v || w_xfer) begin
                            r_ctrl     <= w_load_ctrl;
                            r_instr    <= w_load_word;
                            r_illegal  <= r_illegal | w_load_word[15];
                            r_pend_v   <= 1'b0;
                            r_state    <= S_EXEC;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_ctrl     <= '0;
                            r_instr    <= '0;
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end else if (w_xfer) begin
                        r_pend     <= in_instr;
                        r_pend_v   <= 1'b1;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= ~r_pend_v;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_CTRL_SEQ_PERF_EN
    logic [15:0] r_op_count;

    // Completed-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (w_close) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

    assign in_ready      = r_in_ready;
    assign instr_in      = r_instr;
    assign ALU_Control1  = r_ctrl[9];
    assign ALU_Control0  = r_ctrl[8];
    assign A_mux         = r_ctrl[7];
    assign B_mux1        = r_ctrl[6];
    assign B_mux0        = r_ctrl[5];
    assign SUB           = r_ctrl[4];
    assign STL           = r_ctrl[3];
    assign Adder_Cin     = r_ctrl[2];
    assign mux3_1        = r_ctrl[1];
    assign mux3_0        = r_ctrl[0];
    assign A_Fclkpos     = r_a_stb;
    assign ALU_O_Fclkpos = r_alu_o_stb;
    assign done          = r_done;
    assign illegal       = r_illegal;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: a decode table run through full Bennett
// cycles, with a scoreboard of expected control words, plus hand-written
// sequences for back-to-back, coincident-transfer, overrun and reset cases.

module tb_alu_ctrl_seq;

    localparam int unsigned WIDTH = 13;

    logic             clk;
    logic             reset;
    logic             instFlag;
    logic [WIDTH-1:0] clkpos;
    logic [WIDTH-1:0] clkneg;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_instr;
    logic [15:0]      instr_in;
    logic             ALU_Control0, ALU_Control1, A_mux, B_mux0, B_mux1;
    logic             SUB, STL, Adder_Cin, mux3_0, mux3_1;
    logic             A_Fclkpos, ALU_O_Fclkpos, done, illegal, overrun;
`ifdef ALU_CTRL_SEQ_PERF_EN
    logic [15:0]      op_count;
    int               exp_ops;
`endif

    alu_ctrl_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .instFlag     (instFlag),
        .clkpos       (clkpos),
        .clkneg       (clkneg),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .instr_in     (instr_in),
        .ALU_Control0 (ALU_Control0),
        .ALU_Control1 (ALU_Control1),
        .A_mux        (A_mux),
        .B_mux0       (B_mux0),
        .B_mux1       (B_mux1),
        .SUB          (SUB),
        .STL          (STL),
        .Adder_Cin    (Adder_Cin),
        .mux3_0       (mux3_0),
        .mux3_1       (mux3_1),
        .A_Fclkpos    (A_Fclkpos),
        .ALU_O_Fclkpos(ALU_O_Fclkpos),
        .done         (done),
        .illegal      (illegal),
        .overrun      (overrun)
`ifdef ALU_CTRL_SEQ_PERF_EN
        ,
        .op_count     (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] ctrl_w;
    assign ctrl_w = {ALU_Control1, ALU_Control0, A_mux, B_mux1, B_mux0,
                     SUB, STL, Adder_Cin, mux3_1, mux3_0};

    typedef struct {
        logic [15:0] instr;
        logic [9:0]  ctrl;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [9:0]  ctrl;
    } exp_t;

    vec_t vecs [16];
    exp_t sb [$];
    int   total;
    int   bad;
    logic exp_ill;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expected control word and compare against the loaded outputs
    task automatic sb_check(input string name);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got ctrl %h", name, ctrl_w);
        end else begin
            total--;
            e = sb.pop_front();
            check({name, "_ctrl"}, 32'(ctrl_w), 32'(e.ctrl));
            check({name, "_instr"}, 32'(instr_in), 32'(e.instr));
        end
    endtask

    task automatic send(input logic [15:0] w, input logic [9:0] c);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        in_instr = w;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        e.instr = w;
        e.ctrl  = c;
        sb.push_back(e);
    endtask

    task automatic rise();
        instFlag = 1'b1;
        step();
        instFlag = 1'b0;
    endtask

    task automatic peak();
        clkpos = '1;
        clkneg = '0;
        step();
        clkpos = '0;
    endtask

    // Strobe pair check starting right after the peak was sampled
    task automatic check_strobes(input string name);
        check({name, "_A"}, 32'(A_Fclkpos), 32'd1);
        check({name, "_O_early"}, 32'(ALU_O_Fclkpos), 32'd0);
        step();
        check({name, "_A_off"}, 32'(A_Fclkpos), 32'd0);
        check({name, "_O"}, 32'(ALU_O_Fclkpos), 32'd1);
        step();
        check({name, "_O_off"}, 32'(ALU_O_Fclkpos), 32'd0);
    endtask

    task automatic close_check(input string name);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_ctrl0"}, 32'(ctrl_w), 32'd0);
        check({name, "_instr0"}, 32'(instr_in), 32'd0);
`ifdef ALU_CTRL_SEQ_PERF_EN
        exp_ops++;
        check({name, "_opcnt"}, 32'(op_count), 32'(exp_ops));
`endif
        step();
        check({name, "_done_off"}, 32'(done), 32'd0);
        check({name, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int strobes;
        total   = 0;
        bad     = 0;
        exp_ill = 1'b0;
`ifdef ALU_CTRL_SEQ_PERF_EN
        exp_ops = 0;
`endif

        vecs[0]  = '{16'h0000, 10'b00_0_00_0_0_0_00, 1'b0};
        vecs[1]  = '{16'h1001, 10'b10_1_11_0_0_0_00, 1'b0};
        vecs[2]  = '{16'h2003, 10'b10_1_11_1_0_1_00, 1'b0};
        vecs[3]  = '{16'h3012, 10'b00_1_11_0_0_0_00, 1'b0};
        vecs[4]  = '{16'h4abc, 10'b01_1_11_0_0_0_00, 1'b0};
        vecs[5]  = '{16'h5004, 10'b11_1_11_1_1_1_00, 1'b0};
        vecs[6]  = '{16'h6fff, 10'b10_1_01_0_0_0_00, 1'b0};
        vecs[7]  = '{16'h7123, 10'b10_0_10_0_0_0_01, 1'b0};
        for (int i = 8; i < 16; i++) begin
            vecs[i].instr = {4'(i), 12'h000};
            vecs[i].ctrl  = '0;
            vecs[i].ill   = 1'b1;
        end

        reset    = 1'b1;
        instFlag = 1'b0;
        clkpos   = '0;
        clkneg   = '0;
        in_valid = 1'b0;
        in_instr = '0;
        step();
        step();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_ctrl", 32'(ctrl_w), 32'd0);
        check("rst_instr", 32'(instr_in), 32'd0);
        check("rst_flags", 32'({A_Fclkpos, ALU_O_Fclkpos, done, illegal, overrun}), 32'd0);
        reset = 1'b0;
        step();
        check("rst_ready_rel", 32'(in_ready), 32'd1);

        // Decode table, one full Bennett cycle per entry
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].instr, vecs[i].ctrl);
            check("arm_ready", 32'(in_ready), 32'd0);
            rise();
            sb_check("tbl_load");
            exp_ill = exp_ill | vecs[i].ill;
            check("tbl_illegal", 32'(illegal), 32'(exp_ill));
            step();
            peak();
            check_strobes("tbl");
            rise();
            close_check("tbl");
        end
        check("illegal_sticky", 32'(illegal), 32'd1);
        check("no_overrun", 32'(overrun), 32'd0);

        // Back-to-back: second instruction accepted in HOLD, loaded at first's done
        send(16'h2003, 10'b10_1_11_1_0_1_00);
        rise();
        sb_check("b2b_first");
        peak();
        step();
        check("b2b_hold_ready", 32'(in_ready), 32'd1);
        send(16'h5004, 10'b11_1_11_1_1_1_00);
        check("b2b_pend_ready", 32'(in_ready), 32'd0);
        rise();
        check("b2b_done", 32'(done), 32'd1);
`ifdef ALU_CTRL_SEQ_PERF_EN
        exp_ops++;
`endif
        sb_check("b2b_second");
        check("b2b_no_idle", 32'(in_ready), 32'd0);
        peak();
        check_strobes("b2b");
        rise();
        close_check("b2b");

        // Transfer coincident with flag_rise in HOLD loads straight into EXEC
        send(16'h3000, 10'b00_1_11_0_0_0_00);
        rise();
        sb_check("hx_first");
        peak();
        step();
        in_valid = 1'b1;
        in_instr = 16'h4000;
        instFlag = 1'b1;
        sb.push_back('{16'h4000, 10'b01_1_11_0_0_0_00});
        step();
        in_valid = 1'b0;
        instFlag = 1'b0;
        check("hx_done", 32'(done), 32'd1);
`ifdef ALU_CTRL_SEQ_PERF_EN
        exp_ops++;
`endif
        sb_check("hx_direct");
        peak();
        check_strobes("hx");
        rise();
        close_check("hx");

        // Transfer coincident with flag_rise in IDLE: flag ignored, wait in ARM
        in_valid = 1'b1;
        in_instr = 16'h1001;
        instFlag = 1'b1;
        step();
        in_valid = 1'b0;
        instFlag = 1'b0;
        sb.push_back('{16'h1001, 10'b10_1_11_0_0_0_00});
        check("ic_ctrl_hold", 32'(ctrl_w), 32'd0);
        check("ic_arm_ready", 32'(in_ready), 32'd0);
        step();
        step();
        check("ic_ctrl_still", 32'(ctrl_w), 32'd0);
        rise();
        sb_check("ic_load");
        peak();
        check_strobes("ic");
        rise();
        close_check("ic");

        // No peak in the Bennett cycle: overrun, done, no strobes
        send(16'h1001, 10'b10_1_11_0_0_0_00);
        rise();
        sb_check("ov_load");
        clkpos  = 13'h0FFF;
        clkneg  = '0;
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (A_Fclkpos || ALU_O_Fclkpos) strobes++;
        end
        rise();
        if (A_Fclkpos || ALU_O_Fclkpos) strobes++;
        clkpos = '0;
        check("ov_strobes", 32'(strobes), 32'd0);
        check("ov_overrun", 32'(overrun), 32'd1);
        close_check("ov");

        // Reset right after the operand strobe cancels the result strobe
        send(16'h1001, 10'b10_1_11_0_0_0_00);
        rise();
        sb_check("rs_load");
        peak();
        check("rs_A", 32'(A_Fclkpos), 32'd1);
        reset = 1'b1;
        #1;
        check("rs_async_A", 32'(A_Fclkpos), 32'd0);
        check("rs_ctrl", 32'(ctrl_w), 32'd0);
        step();
        check("rs_no_O", 32'(ALU_O_Fclkpos), 32'd0);
        check("rs_flags", 32'({done, illegal, overrun, in_ready}), 32'd0);
        check("rs_instr", 32'(instr_in), 32'd0);
`ifdef ALU_CTRL_SEQ_PERF_EN
        exp_ops = 0;
        check("rs_opcnt", 32'(op_count), 32'd0);
`endif
        reset = 1'b0;
        step();
        check("rs_ready_rel", 32'(in_ready), 32'd1);
        check("rs_O_still", 32'(ALU_O_Fclkpos), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter WIDTH, default 13, number of Bennett clock phases observed on clkpos/clkneg.
REQ-002 clk  input  1  system clock; every register samples on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instFlag  input  1  Bennett cycle boundary flag from bennett_clock.
REQ-005 clkpos / clkneg  input  WIDTH each  Bennett phase rails, used only for peak detection.
REQ-006 in_valid / in_ready  input / output  1 each  instruction handshake; transfer when both are high on a clk edge.
REQ-007 in_instr  input  16  instruction word; opcode is bits [15:12].
REQ-008 instr_in  output  16  held instruction word, driven to the ALU immediate path.
REQ-009 ALU_Control0, ALU_Control1, A_mux, B_mux0, B_mux1, SUB, STL, Adder_Cin, mux3_0, mux3_1  output  1 each  ALU control bits.
REQ-010 A_Fclkpos / ALU_O_Fclkpos  output  1 each  one-clk latch strobes for the ALU operand and result flops.
REQ-011 done  output  1  one-clk pulse when an executed instruction's Bennett cycle closes.
REQ-012 illegal  output  1  sticky flag: an opcode of 8-15 was executed.
REQ-013 overrun  output  1  sticky flag: a Bennett cycle closed with no peak seen.

Function
REQ-014 States: IDLE, ARM, EXEC, HOLD.
REQ-015 Edge: flag_rise = instFlag high while its one-clk registered copy is low.
REQ-016 Peak: clkpos all ones and clkneg all zeros in the same cycle.
REQ-017 in_ready = 1 in IDLE, and in HOLD while the pending register is empty; 0 otherwise.
REQ-018 IDLE: on transfer, capture in pending and go to ARM; a flag_rise in that same cycle is ignored.
REQ-019 ARM: on flag_rise, load pending into the control/instr_in registers, clear pending, go to EXEC.
REQ-020 EXEC: on the first peak, pulse A_Fclkpos for that cycle and ALU_O_Fclkpos for the next cycle, then go to HOLD.
REQ-021 EXEC: on flag_rise with no peak seen, set overrun, assert done, and follow the HOLD flag_rise rules.
REQ-022 HOLD: a transfer captures into pending.
REQ-023 HOLD: on flag_rise, assert done; with pending full, load it and go to EXEC; otherwise drive all controls and instr_in to 0 and go to IDLE.
REQ-024 HOLD: a transfer in the same cycle as flag_rise goes directly into the loaded controls and enters EXEC.
REQ-025 Control outputs and instr_in change only on a flag_rise cycle; they are stable across the whole Bennett cycle.
REQ-026 Decode, listing {ALU_Control1,ALU_Control0}, A_mux, {B_mux1,B_mux0}, SUB, STL, Adder_Cin, {mux3_1,mux3_0}:
  0 NOP: all zero.
  1 ADD: 10, 1, 11, 0, 0, 0, 00.
  2 SUB: 10, 1, 11, 1, 0, 1, 00.
  3 AND: 00, 1, 11, 0, 0, 0, 00.
  4 OR: 01, 1, 11, 0, 0, 0, 00.
  5 SLT: 11, 1, 11, 1, 1, 1, 00.
  6 ADDI: 10, 1, 01, 0, 0, 0, 00.
  7 PCADD: 10, 0, 10, 0, 0, 0, 01.
  8-15: decoded as NOP, and illegal is set at load.
REQ-027 A strobe is never issued outside EXEC; at most one strobe pair per Bennett cycle.

Reset
REQ-028 Reset asserted: state goes to IDLE and pending is emptied.
REQ-029 Reset asserted: all controls, instr_in, strobes, done, illegal and overrun go to 0, and the edge register is cleared.
REQ-030 Reset mid-EXEC cancels any outstanding ALU_O_Fclkpos strobe.
REQ-031 in_ready is 0 while reset is high and reaches 1 on the first clk edge after release.

Configuration
REQ-032 Macro ALU_CTRL_SEQ_PERF_EN defined: add a 16-bit output op_count, reset to 0, incremented on each done pulse, wrapping from 65535 to 0.
REQ-033 Macro undefined: op_count does not exist and behaviour is otherwise identical.

Verification
REQ-034 ADD 0x1001 sent in IDLE -> controls 10,1,11,0,0,0,00 at the next flag_rise -> A_Fclkpos at peak, ALU_O_Fclkpos one cycle later -> done at the following flag_rise, then all controls 0.
REQ-035 Back-to-back SUB 0x2003 then SLT 0x5004 -> the second instruction is accepted in HOLD and loaded on the same flag_rise as the first instruction's done -> no IDLE gap.
REQ-036 Opcode 0xA000 -> outputs equal NOP and illegal latches to 1 until reset.
REQ-037 clkpos held at 0x0FFF (peak never reached) through one Bennett cycle -> no strobes, overrun = 1, done pulses.
REQ-038 Transfer coincident with flag_rise in IDLE -> state ARM, controls unchanged until the next flag_rise.
REQ-039 Reset asserted in EXEC one cycle after A_Fclkpos -> no ALU_O_Fclkpos, all outputs 0, in_ready = 1 after release; with ALU_CTRL_SEQ_PERF_EN, op_count = 0.
